// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_ctrl_pkg                                             |
// | Desc     : Opcodes, encodings and control bundle for pipe_ctrl       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pipe_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_XOR   = 2'b11;

  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic [1:0] alu_op;
    logic       branch;
    logic       bne;
    logic       jump;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       sign_zero;
  } ctrl_t;

  localparam ctrl_t BUBBLE = '0;

  // Opcodes whose rt field is a source operand rather than a destination.
  function automatic logic reads_rt(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_ctrl_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : ctrl_decoder                                              |
// | Desc     : Combinational opcode to control-bundle decoder            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module ctrl_decoder
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic                id_valid_i,
  input  logic [OPCODE_W-1:0] opcode_i,
  output ctrl_t               ctrl_o,
  output logic                illegal_o
);

  always_comb begin
    ctrl_o    = BUBBLE;
    illegal_o = 1'b0;
    if (id_valid_i) begin
      case (opcode_i)
        OP_RTYPE: begin
          ctrl_o.reg_dst   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_FUNCT;
        end
        OP_LW: begin
          ctrl_o.alu_src    = 1'b1;
          ctrl_o.mem_to_reg = 1'b1;
          ctrl_o.reg_write  = 1'b1;
          ctrl_o.mem_read   = 1'b1;
          ctrl_o.alu_op     = ALU_ADD;
          ctrl_o.sign_zero  = 1'b1;
        end
        OP_SW: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.mem_write = 1'b1;
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.sign_zero = 1'b1;
        end
        OP_BEQ: begin
          ctrl_o.branch    = 1'b1;
          ctrl_o.alu_op    = ALU_SUB;
          ctrl_o.sign_zero = 1'b1;
        end
        OP_BNE: begin
          ctrl_o.branch    = 1'b1;
          ctrl_o.bne       = 1'b1;
          ctrl_o.alu_op    = ALU_SUB;
          ctrl_o.sign_zero = 1'b1;
        end
        OP_ADDI: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_ADD;
          ctrl_o.sign_zero = 1'b1;
        end
        OP_XORI: begin
          ctrl_o.alu_src   = 1'b1;
          ctrl_o.reg_write = 1'b1;
          ctrl_o.alu_op    = ALU_XOR;
        end
        OP_J: begin
          ctrl_o.jump = 1'b1;
        end
        default: begin
          illegal_o = 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pipe_ctrl                                                 |
// | Desc     : 5-stage pipeline control: decode, hazards, branch/jump    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int OPCODE_W   = 6,
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [OPCODE_W-1:0]   id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  ex_zero,
  output logic                  stall_if,
  output logic                  flush_ifid,
  output logic [1:0]            pc_sel,
  output logic                  ex_reg_dst,
  output logic                  ex_alu_src,
  output logic [ALUOP_W-1:0]    ex_alu_op,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  wb_reg_write,
  output logic                  wb_mem_to_reg,
  output logic [REG_ADDR_W-1:0] wb_dst,
  output logic                  illegal
);

  ctrl_t                 w_dec;
  logic                  w_dec_illegal;
  ctrl_t                 w_id_ctrl;
  logic [REG_ADDR_W-1:0] w_dst;
  logic                  w_taken;
  logic                  w_hazard;
  logic                  w_jump;
  logic                  w_bubble;
  logic                  w_unused;

  ctrl_t                 idex_ctrl_q, idex_ctrl_d;
  logic [REG_ADDR_W-1:0] idex_dst_q, idex_dst_d;
  logic                  exmem_mem_read_q, exmem_mem_write_q;
  logic                  exmem_reg_write_q, exmem_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] exmem_dst_q;
  logic                  memwb_reg_write_q, memwb_mem_to_reg_q;
  logic [REG_ADDR_W-1:0] memwb_dst_q;
  logic                  illegal_q, illegal_d;

  ctrl_decoder #(
    .OPCODE_W (OPCODE_W)
  ) u_decoder (
    .id_valid_i (id_valid),
    .opcode_i   (id_opcode),
    .ctrl_o     (w_dec),
    .illegal_o  (w_dec_illegal)
  );

  assign w_dst = w_dec.reg_dst ? id_rd : id_rt;

  // Writes to $0 are architecturally discarded, so drop them at decode.
  always_comb begin
    w_id_ctrl = w_dec;
    if (w_dst == '0) begin
      w_id_ctrl.reg_write = 1'b0;
    end
  end

  assign w_taken  = idex_ctrl_q.branch & (ex_zero ^ idex_ctrl_q.bne);
  assign w_hazard = id_valid & idex_ctrl_q.mem_read & (idex_dst_q != '0) &
                    ((idex_dst_q == id_rs) | (reads_rt(id_opcode) & (idex_dst_q == id_rt)));
  assign w_jump   = rst_n & w_dec.jump & ~w_taken & ~w_hazard;

  assign stall_if   = w_hazard & ~w_taken;
  assign flush_ifid = w_taken | w_jump;
  assign pc_sel     = w_taken ? PC_BRANCH : (w_jump ? PC_JUMP : PC_PLUS4);

  assign w_bubble = ~id_valid | w_dec_illegal | w_taken | w_hazard | w_dec.jump;

  always_comb begin
    idex_ctrl_d = w_id_ctrl;
    idex_dst_d  = w_dst;
    if (w_bubble) begin
      idex_ctrl_d = BUBBLE;
      idex_dst_d  = '0;
    end
  end

  // A wrong-path opcode squashed by a taken branch never really issued.
  assign illegal_d = illegal_q | (w_dec_illegal & ~w_taken);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idex_ctrl_q        <= BUBBLE;
      idex_dst_q         <= '0;
      exmem_mem_read_q   <= 1'b0;
      exmem_mem_write_q  <= 1'b0;
      exmem_reg_write_q  <= 1'b0;
      exmem_mem_to_reg_q <= 1'b0;
      exmem_dst_q        <= '0;
      memwb_reg_write_q  <= 1'b0;
      memwb_mem_to_reg_q <= 1'b0;
      memwb_dst_q        <= '0;
      illegal_q          <= 1'b0;
    end else begin
      idex_ctrl_q        <= idex_ctrl_d;
      idex_dst_q         <= idex_dst_d;
      exmem_mem_read_q   <= idex_ctrl_q.mem_read;
      exmem_mem_write_q  <= idex_ctrl_q.mem_write;
      exmem_reg_write_q  <= idex_ctrl_q.reg_write;
      exmem_mem_to_reg_q <= idex_ctrl_q.mem_to_reg;
      exmem_dst_q        <= idex_dst_q;
      memwb_reg_write_q  <= exmem_reg_write_q;
      memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
      memwb_dst_q        <= exmem_dst_q;
      illegal_q          <= illegal_d;
    end
  end

  assign ex_reg_dst    = idex_ctrl_q.reg_dst;
  assign ex_alu_src    = idex_ctrl_q.alu_src;
  assign ex_alu_op     = ALUOP_W'(idex_ctrl_q.alu_op);
  assign mem_read      = exmem_mem_read_q;
  assign mem_write     = exmem_mem_write_q;
  assign wb_reg_write  = memwb_reg_write_q;
  assign wb_mem_to_reg = memwb_mem_to_reg_q;
  assign wb_dst        = memwb_dst_q;
  assign illegal       = illegal_q;

  assign w_unused = idex_ctrl_q.jump ^ idex_ctrl_q.sign_zero;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pipe_ctrl                                              |
// | Desc     : Scoreboard bench for pipe_ctrl with instruction-level model|
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_pipe_ctrl;

  localparam bit [5:0] C_R    = 6'b000000;
  localparam bit [5:0] C_LW   = 6'b100011;
  localparam bit [5:0] C_SW   = 6'b101011;
  localparam bit [5:0] C_BEQ  = 6'b000100;
  localparam bit [5:0] C_BNE  = 6'b000101;
  localparam bit [5:0] C_ADDI = 6'b001000;
  localparam bit [5:0] C_XORI = 6'b001110;
  localparam bit [5:0] C_J    = 6'b000010;

  logic       clk;
  logic       rst_n;
  logic       id_valid;
  logic [5:0] id_opcode;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;
  logic       stall_if, flush_ifid;
  logic [1:0] pc_sel;
  logic       ex_reg_dst, ex_alu_src;
  logic [1:0] ex_alu_op;
  logic       mem_read, mem_write;
  logic       wb_reg_write, wb_mem_to_reg;
  logic [4:0] wb_dst;
  logic       illegal;

  pipe_ctrl #(
    .OPCODE_W   (6),
    .REG_ADDR_W (5),
    .ALUOP_W    (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .ex_zero       (ex_zero),
    .stall_if      (stall_if),
    .flush_ifid    (flush_ifid),
    .pc_sel        (pc_sel),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_src    (ex_alu_src),
    .ex_alu_op     (ex_alu_op),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .wb_dst        (wb_dst),
    .illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One in-flight instruction as the programmer sees it.
  typedef struct {
    bit       v;
    bit [5:0] op;
    bit [4:0] dst;
  } instr_t;

  typedef struct {
    bit       stall;
    bit       flush;
    bit [1:0] pcsel;
    bit [3:0] exc;
    bit [1:0] memc;
    bit [1:0] wbc;
    bit [4:0] wbdst;
    bit       ill;
  } exp_t;

  exp_t   sb[$];
  instr_t m_ex, m_mem, m_wb;
  bit     m_ill;
  int     checks = 0;
  int     errors = 0;

  function automatic bit is_legal(input bit [5:0] op);
    return op inside {C_R, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_XORI, C_J};
  endfunction

  function automatic bit uses_rt(input bit [5:0] op);
    return op inside {C_R, C_SW, C_BEQ, C_BNE};
  endfunction

  // {reg_dst, alu_src, alu_op} straight from the decode table
  function automatic bit [3:0] ex_view(input instr_t i);
    if (!i.v) return 4'b0000;
    case (i.op)
      C_R:                  return 4'b1010;
      C_LW, C_SW, C_ADDI:   return 4'b0100;
      C_BEQ, C_BNE:         return 4'b0001;
      C_XORI:               return 4'b0111;
      default:              return 4'b0000;
    endcase
  endfunction

  function automatic bit [1:0] mem_view(input instr_t i);
    return {i.v && i.op == C_LW, i.v && i.op == C_SW};
  endfunction

  function automatic bit [1:0] wb_view(input instr_t i);
    bit writes;
    writes = i.v && (i.op inside {C_R, C_LW, C_ADDI, C_XORI}) && i.dst != 0;
    return {writes, i.v && i.op == C_LW};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_ex  = '{0, 6'd0, 5'd0};
    m_mem = '{0, 6'd0, 5'd0};
    m_wb  = '{0, 6'd0, 5'd0};
    m_ill = 1'b0;
  endtask

  task automatic rst_cycle();
    exp_t e;
    @(negedge clk);
    rst_n    = 1'b0;
    id_valid = 1'b0;
    clear_model();
    e = '{0, 0, 2'd0, 4'd0, 2'd0, 2'd0, 5'd0, 0};
    sb.push_back(e);
  endtask

  task automatic cycle(input bit v, input bit [5:0] op, input bit [4:0] rs,
                       input bit [4:0] rt, input bit [4:0] rd, input bit z,
                       output bit st, output bit fl);
    exp_t e;
    bit   taken, hz, jp;
    @(negedge clk);
    rst_n     = 1'b1;
    id_valid  = v;
    id_opcode = op;
    id_rs     = rs;
    id_rt     = rt;
    id_rd     = rd;
    ex_zero   = z;

    taken = m_ex.v && ((m_ex.op == C_BEQ && z) || (m_ex.op == C_BNE && !z));
    hz    = v && m_ex.v && m_ex.op == C_LW && m_ex.dst != 0 &&
            (m_ex.dst == rs || (uses_rt(op) && m_ex.dst == rt));
    st    = hz && !taken;
    jp    = v && op == C_J && !taken && !hz;
    fl    = taken || jp;

    e.stall = st;
    e.flush = fl;
    e.pcsel = taken ? 2'b01 : (jp ? 2'b10 : 2'b00);
    e.exc   = ex_view(m_ex);
    e.memc  = mem_view(m_mem);
    e.wbc   = wb_view(m_wb);
    e.wbdst = m_wb.v ? m_wb.dst : 5'd0;
    e.ill   = m_ill;
    sb.push_back(e);

    if (v && !is_legal(op) && !taken) m_ill = 1'b1;
    m_wb  = m_mem;
    m_mem = m_ex;
    if (!v || taken || hz || op == C_J || !is_legal(op))
      m_ex = '{0, 6'd0, 5'd0};
    else
      m_ex = '{1, op, (op == C_R) ? rd : rt};
  endtask

  // Models the fetch side: a stalled instruction is re-presented, a flush leaves a bubble.
  task automatic issue(input bit [5:0] op, input bit [4:0] rs, input bit [4:0] rt,
                       input bit [4:0] rd, input bit z);
    bit st, fl;
    int n = 0;
    do begin
      cycle(1'b1, op, rs, rt, rd, z, st, fl);
      n++;
    end while (st && n < 3);
    if (fl) cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, st, fl);
  endtask

  task automatic idle(input int n);
    bit st, fl;
    for (int i = 0; i < n; i++) cycle(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, st, fl);
  endtask

  function automatic bit [5:0] rand_op();
    bit [5:0] ops [8];
    ops = '{C_R, C_LW, C_SW, C_BEQ, C_BNE, C_ADDI, C_XORI, C_J};
    return ops[$urandom_range(0, 7)];
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("stall_if",   stall_if,   e.stall);
        check("flush_ifid", flush_ifid, e.flush);
        check("pc_sel",     pc_sel,     e.pcsel);
        check("ex_ctrl",    {ex_reg_dst, ex_alu_src, ex_alu_op}, e.exc);
        check("mem_ctrl",   {mem_read, mem_write}, e.memc);
        check("wb_ctrl",    {wb_reg_write, wb_mem_to_reg}, e.wbc);
        check("wb_dst",     wb_dst,     e.wbdst);
        check("illegal",    illegal,    e.ill);
      end
    end
  end

  initial begin : stimulus
    bit       st, fl, v, z;
    bit [5:0] op;
    bit [4:0] rs, rt, rd;
    rst_n = 1'b0; id_valid = 1'b0; id_opcode = '0;
    id_rs = '0; id_rt = '0; id_rd = '0; ex_zero = 1'b0;
    clear_model();

    rst_cycle();
    rst_cycle();

    issue(C_LW, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(C_R,  5'd2, 5'd4, 5'd3, 1'b0);
    idle(4);

    issue(C_BEQ, 5'd1, 5'd1, 5'd0, 1'b0);
    issue(C_R,   5'd5, 5'd6, 5'd7, 1'b1);
    issue(C_BEQ, 5'd1, 5'd1, 5'd0, 1'b0);
    issue(C_R,   5'd5, 5'd6, 5'd7, 1'b0);
    issue(C_BNE, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(C_R,   5'd5, 5'd6, 5'd7, 1'b1);
    issue(C_BNE, 5'd1, 5'd2, 5'd0, 1'b0);
    issue(C_R,   5'd5, 5'd6, 5'd7, 1'b0);

    issue(C_LW,  5'd1, 5'd2, 5'd0, 1'b0);
    issue(C_BEQ, 5'd3, 5'd3, 5'd0, 1'b0);
    issue(C_R,   5'd2, 5'd2, 5'd5, 1'b1);

    issue(C_J, 5'd0, 5'd0, 5'd0, 1'b0);
    idle(2);

    issue(C_ADDI, 5'd1, 5'd0, 5'd0, 1'b0);
    issue(C_XORI, 5'd1, 5'd6, 5'd0, 1'b0);
    issue(C_SW,   5'd6, 5'd6, 5'd0, 1'b0);
    idle(4);

    issue(C_LW, 5'd1, 5'd2, 5'd0, 1'b0);
    idle(1);
    rst_cycle();
    rst_cycle();
    idle(1);
    issue(C_LW, 5'd1, 5'd3, 5'd0, 1'b0);
    issue(C_LW, 5'd3, 5'd2, 5'd0, 1'b0);
    issue(C_SW, 5'd4, 5'd2, 5'd0, 1'b0);
    idle(4);

    st = 1'b0; fl = 1'b0;
    v = 1'b0; op = '0; rs = '0; rt = '0; rd = '0;
    for (int i = 0; i < 400; i++) begin
      if (!st) begin
        if (fl) begin
          v = 1'b0;
        end else begin
          v  = ($urandom_range(0, 9) != 0);
          op = rand_op();
          rs = 5'($urandom_range(0, 3));
          rt = 5'($urandom_range(0, 3));
          rd = 5'($urandom_range(0, 3));
        end
      end
      z = 1'($urandom_range(0, 1));
      cycle(v, op, rs, rt, rd, z, st, fl);
    end
    idle(4);

    issue(6'b111111, 5'd1, 5'd2, 5'd3, 1'b0);
    for (int i = 0; i < 10; i++)
      issue(rand_op(), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    idle(4);

    @(negedge clk);
    #4;
    check("scoreboard_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
